// File: rtl/fetch_pc_predict.sv
// fetch_pc_predict: fetch-stage PC generator feeding the branch target buffer.
// Owns the fetch PC, drives BTB index/write, and redirects fetch on
// predicted-taken branches using the registered BTB read data.
// Optional feature macro: FETCH_BHT_EN adds a 2-bit-counter branch history
// table that must agree (counter MSB set) before a BTB hit redirects fetch.
// Naming note: prev_pc_q is the previous fetch PC (the PC whose BTB read is
// arriving on btb_target this cycle); *_d are always next-state values.
module fetch_pc_predict #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic [31:0]      btb_target,
    output logic [IDX_W-1:0] btb_index,
    output logic             btb_write,
    output logic [31:0]      btb_load,
    output logic [31:0]      pc,
    output logic             fetch_valid,
    output logic             pred_taken
);

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] prev_pc_q, prev_pc_d;
    logic        pd_valid_q, pd_valid_d;
    logic        btb_ok_q;

    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] prev_idx;
    logic             pred_gate;
    logic             hit;

    assign cur_idx  = pc_q[IDX_W+1:2];
    assign prev_idx = prev_pc_q[IDX_W+1:2];

    // A taken resolution installs its target; not-taken never touches the BTB.
    assign btb_write = upd_valid & upd_taken;
    assign btb_load  = upd_target;

    // Writes own the BTB port; a stall re-reads the pending branch's entry so
    // btb_target stays valid for that branch until the stall releases.
    assign btb_index = btb_write ? upd_idx : (stall ? prev_idx : cur_idx);

    assign pc = pc_q;

`ifdef FETCH_BHT_EN
    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] bht_q [0:DEPTH-1];
    logic [1:0] bht_prev_q, bht_prev_d;
    logic [1:0] bht_upd_old;

    assign bht_upd_old = bht_q[upd_idx];
    assign pred_gate   = bht_prev_q[1];

    // Saturating 2-bit counters trained by resolved branches; reset weakly not-taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && (bht_upd_old != 2'b11)) begin
                bht_q[upd_idx] <= bht_upd_old + 2'b01;
            end else if (!upd_taken && (bht_upd_old != 2'b00)) begin
                bht_q[upd_idx] <= bht_upd_old - 2'b01;
            end
        end
    end

    // Counter value captured alongside prev_pc_q so it lines up with btb_target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bht_prev_q <= 2'b00;
        end else begin
            bht_prev_q <= bht_prev_d;
        end
    end
`else
    assign pred_gate = 1'b1;
`endif

    // A zero target means an empty BTB entry, never a real prediction.
    assign hit = pd_valid_q & btb_ok_q & pred_gate & (btb_target != 32'd0);

    // State, PC pipeline and BTB-read tracking registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            prev_pc_q  <= 32'd0;
            pd_valid_q <= 1'b0;
            btb_ok_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            prev_pc_q  <= prev_pc_d;
            pd_valid_q <= pd_valid_d;
            btb_ok_q   <= ~btb_write;
        end
    end

    // Next-PC selection: redirect, then stall, then prediction, then sequential.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        prev_pc_d   = prev_pc_q;
        pd_valid_d  = pd_valid_q;
        fetch_valid = 1'b0;
        pred_taken  = 1'b0;
`ifdef FETCH_BHT_EN
        bht_prev_d  = bht_prev_q;
`endif
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                fetch_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    pd_valid_d  = 1'b0;
                    fetch_valid = 1'b0;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (hit) begin
                    pc_d        = btb_target;
                    pred_taken  = 1'b1;
                    fetch_valid = 1'b0;
                    pd_valid_d  = 1'b0;
                end else begin
                    pc_d       = pc_q + 32'd4;
                    prev_pc_d  = pc_q;
                    pd_valid_d = 1'b1;
`ifdef FETCH_BHT_EN
                    bht_prev_d = bht_q[cur_idx];
`endif
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

endmodule
